// File: rtl/ca2_serial.sv
// rtl/ca2_serial.sv - bit-serial two's-complement negate / absolute value with CVNZ flags
//
// Computes R = -A (mode=0, NEG) or R = |A| (mode=1, ABS) one bit per clock,
// LSB first, using the copy-until-first-one-then-invert rule.
// Optional macro CA2_SAT_EN: saturate the overflow case (A == MIN) to the
// maximum positive value instead of wrapping to MIN.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   operation request, sampled only when idle
//   mode   in   0 = NEG, 1 = ABS, latched with start
//   A      in   operand, latched with start
//   R      out  result register
//   CCR    out  condition codes {C,V,N,Z} placed by the *_mask parameters
//   busy   out  operation in progress
//   done   out  one-cycle pulse when R/CCR update

module ca2_serial #(
    parameter int         op_size = 4,
    parameter logic [3:0] c_mask  = 4'b1000,
    parameter logic [3:0] v_mask  = 4'b0100,
    parameter logic [3:0] n_mask  = 4'b0010,
    parameter logic [3:0] z_mask  = 4'b0001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [op_size-1:0] A,
    output logic [op_size-1:0] R,
    output logic [3:0]         CCR,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(op_size);
    localparam logic [CW-1:0] LAST_BIT = CW'(op_size - 1);
    localparam logic [op_size-1:0] MIN_VAL = {1'b1, {(op_size-1){1'b0}}};
`ifdef CA2_SAT_EN
    localparam logic [op_size-1:0] MAX_VAL = {1'b0, {(op_size-1){1'b1}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [op_size-1:0] a_q, a_d;       // operand, shifted right each bit
    logic [op_size-1:0] res_q, res_d;   // result, filled from the MSB side
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               seen_q, seen_d; // a one has already passed through
    logic               inv_q, inv_d;   // negation is actually performed
    logic               mode_q, mode_d;
    logic               sign_q, sign_d; // sign of the latched operand
    logic [op_size-1:0] r_q, r_d;
    logic [3:0]         ccr_q, ccr_d;
    logic               done_q, done_d;

    logic               a_bit;
    logic               out_bit;
    logic               v_flag;
    logic               c_flag;
    logic [op_size-1:0] r_fin;

    assign a_bit   = a_q[0];
    assign out_bit = (inv_q & seen_q) ? ~a_bit : a_bit;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        inv_d   = inv_q;
        mode_d  = mode_q;
        sign_d  = sign_q;
        r_d     = r_q;
        ccr_d   = ccr_q;
        done_d  = 1'b0;
        v_flag  = 1'b0;
        c_flag  = 1'b0;
        r_fin   = res_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    mode_d  = mode;
                    sign_d  = A[op_size-1];
                    inv_d   = ~mode | A[op_size-1];
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                res_d  = {out_bit, res_q[op_size-1:1]};
                a_d    = {1'b0, a_q[op_size-1:1]};
                seen_d = seen_q | a_bit;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Only MIN produces MIN in either mode: every other negative
                // operand gives a positive |A|, and -A == MIN only for A == MIN.
                v_flag = (res_q == MIN_VAL);
                // NEG carries whenever A is nonzero (seen_q); ABS only when
                // it actually negated a negative operand.
                c_flag = mode_q ? sign_q : seen_q;
`ifdef CA2_SAT_EN
                if (v_flag) begin
                    r_fin = MAX_VAL;
                end
`endif
                r_d = r_fin;
                ccr_d = (c_flag                 ? c_mask : 4'b0000)
                      | (v_flag                 ? v_mask : 4'b0000)
                      | (r_fin[op_size-1]       ? n_mask : 4'b0000)
                      | ((r_fin == '0)          ? z_mask : 4'b0000);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            inv_q   <= 1'b0;
            mode_q  <= 1'b0;
            sign_q  <= 1'b0;
            r_q     <= '0;
            ccr_q   <= 4'b0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            inv_q   <= inv_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
            r_q     <= r_d;
            ccr_q   <= ccr_d;
            done_q  <= done_d;
        end
    end

    assign R    = r_q;
    assign CCR  = ccr_q;
    assign done = done_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: doc/ca2_serial.md
Name: ca2_serial

Overview:
Clocked, parametrised successor of the two's-complement negator. It computes R = -A (NEG mode) or R = |A| (ABS mode) bit-serially, LSB first, one bit per clock, using the copy-until-first-one-then-invert rule. It produces the same 4-flag CVNZ condition code register as the combinational version. It sits in the datapath where area matters more than latency and handshakes with its controller via start/busy/done.

Parameters:
op_size, 4, operand/result width in bits (>=2)
c_mask, 'b1000, CCR carry bit mask
v_mask, 'b0100, CCR overflow bit mask
n_mask, 'b0010, CCR negative bit mask
z_mask, 'b0001, CCR zero bit mask

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
mode  input  1  0 = NEG (R=-A), 1 = ABS (R=|A|); latched with start
A  input  op_size  operand; latched with start
R  output  op_size  result register
CCR  output  4  condition codes {C,V,N,Z}
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when R/CCR update

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, R=0, CCR=4'b0000, busy=0, done=0, internal shift/count/seen_one cleared. No result is produced for an aborted operation.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on rising edge with start=1, latch A into the shift register and mode. Set inv = (mode==NEG) | A[op_size-1], count=0, seen_one=0. Go to SHIFT, busy=1.
- SHIFT, one bit per clock, LSB first:
  - out_bit = (inv & seen_one) ? ~a_bit : a_bit
  - seen_one |= a_bit
  - out_bit is shifted into the result shift register from the MSB side; count increments.
  - After op_size bits, go to DONE.
- DONE, one cycle: register R, compute and register CCR, done=1, busy=0. Next state is IDLE.
- Latency: R/CCR/done update on the (op_size+1)th rising edge after the edge that sampled start. busy=1 from the sampling edge until the done edge. done is high for exactly one cycle.
- start while busy or during DONE is ignored, not queued. Back-to-back operation requires start=1 in the cycle after done.
- R and CCR hold their values between completions. A and mode may change freely after the sampling edge.
- All arithmetic is modulo 2^op_size. The most-negative value (MIN = 1 followed by zeros) maps to itself.
- Flags, all written together in DONE:
  - NEG mode:
    - C = (A!=0)
    - V = (A==MIN)
    - N = R[op_size-1]
    - Z = (R==0)
  - ABS mode:
    - C = A[op_size-1] (negation performed)
    - V = (A==MIN)
    - N = R[op_size-1]
    - Z = (R==0)

Optional Feature:
CA2_SAT_EN:
- Defined: when V would be set, R is forced to the max positive value (0 followed by ones) instead of MIN. Flags are computed on the saturated R, so N=0 and Z=0, while V=1 and C=1 are kept. Latency is unchanged.
- Undefined: wrap-around result (R=MIN, N=1), as described above.

Test Plan:
- op_size=4, NEG, A=0011, start one cycle -> busy for 5 cycles, done pulse on 5th edge, R=1101, CCR=1010.
- NEG, A=0000 -> R=0000, CCR=0001. ABS, A=0101 -> R=0101, CCR=0000.
- NEG, A=1000 -> R=1000, CCR=1110. With CA2_SAT_EN: R=0111, CCR=1100. ABS, A=1010 -> R=0110, CCR=1000.
- start held high continuously while A changes during SHIFT -> only the first A processed. Next operation accepted the cycle after done. Results R/CCR unchanged until its done.
- rst asserted asynchronously at cycle 2 of SHIFT -> immediately R=0000, CCR=0000, busy=0, done=0. No done pulse afterwards. New start after release works normally.
